// File: rtl/fnd_scan_sched.sv
// fnd_scan_sched: six-digit seven-segment scan scheduler.
// Time-shares the segment bus with dead time, tear-free frame swap and blink.
// Ports:
//   clk, rst          clock, async active-high reset
//   i_frame_seg[41:0] {d5..d0} segment codes, d0 = [6:0]
//   i_frame_dp[5:0]   decimal point per digit
//   i_blink_mask[5:0] 1 = digit blinks
//   i_frame_vld       frame offer
//   o_frame_rdy       frame slot free
//   o_seg, o_seg_dp   drive for the lit digit
//   o_seg_enb[5:0]    common-node enables, active-low
//   o_frame_done      pulse when the last digit slot ends
module fnd_scan_sched #(
  parameter int unsigned DIGIT_CLKS   = 50000,
  parameter int unsigned DEAD_CLKS    = 500,
  parameter int unsigned BLINK_FRAMES = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [41:0] i_frame_seg,
  input  logic [5:0]  i_frame_dp,
  input  logic [5:0]  i_blink_mask,
  input  logic        i_frame_vld,
  output logic        o_frame_rdy,
  output logic [6:0]  o_seg,
  output logic        o_seg_dp,
  output logic [5:0]  o_seg_enb,
  output logic        o_frame_done
);

  typedef enum logic {S_BLANK, S_ON} state_t;

  state_t      state, state_nx;
  logic [31:0] cnt, cnt_nx;
  logic [2:0]  idx, idx_nx;
  logic        bound;

  logic [41:0] act_seg, pnd_seg;
  logic [5:0]  act_dp, pnd_dp;
  logic [5:0]  act_mask, pnd_mask;
  logic        phase;
  logic [31:0] frm_cnt;
  logic        xfer;

  logic [6:0]  seg_nx;
  logic        dp_nx;
  logic [5:0]  enb_nx;
  logic [5:0]  bit_ofs;

  // o_frame_rdy doubles as the inverted pending flag
  assign xfer    = i_frame_vld && o_frame_rdy;
  assign bit_ofs = {3'd0, idx_nx} * 6'd7;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt - 32'd1;
    idx_nx   = idx;
    bound    = 1'b0;
    seg_nx   = 7'd0;
    dp_nx    = 1'b0;
    enb_nx   = 6'h3f;
    unique case (state)
      S_BLANK: begin
        if (cnt == 32'd0) begin
          state_nx = S_ON;
          cnt_nx   = 32'(DIGIT_CLKS - 1);
        end
      end
      S_ON: begin
        if (cnt == 32'd0) begin
          state_nx = S_BLANK;
          cnt_nx   = 32'(DEAD_CLKS - 1);
          if (idx == 3'd5) begin
            idx_nx = 3'd0;
            bound  = 1'b1;
          end else begin
            idx_nx = idx + 3'd1;
          end
        end
      end
    endcase
    // outputs are registered, so decode from the next state
    if (state_nx == S_ON) begin
      enb_nx[idx_nx] = 1'b0;
      if (!(phase && act_mask[idx_nx])) begin
        seg_nx = act_seg[bit_ofs +: 7];
        dp_nx  = act_dp[idx_nx];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_BLANK;
      cnt          <= 32'(DEAD_CLKS - 1);
      idx          <= 3'd0;
      o_seg        <= 7'd0;
      o_seg_dp     <= 1'b0;
      o_seg_enb    <= 6'h3f;
      o_frame_done <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      idx          <= idx_nx;
      o_seg        <= seg_nx;
      o_seg_dp     <= dp_nx;
      o_seg_enb    <= enb_nx;
      o_frame_done <= bound;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_seg     <= '0;
      act_dp      <= '0;
      act_mask    <= '0;
      pnd_seg     <= '0;
      pnd_dp      <= '0;
      pnd_mask    <= '0;
      o_frame_rdy <= 1'b1;
    end else if (bound && !o_frame_rdy) begin
      act_seg     <= pnd_seg;
      act_dp      <= pnd_dp;
      act_mask    <= pnd_mask;
      o_frame_rdy <= 1'b1;
    end else if (xfer) begin
      pnd_seg     <= i_frame_seg;
      pnd_dp      <= i_frame_dp;
      pnd_mask    <= i_blink_mask;
      o_frame_rdy <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frm_cnt <= '0;
      phase   <= 1'b0;
    end else if (bound) begin
      if (frm_cnt == 32'(BLINK_FRAMES - 1)) begin
        frm_cnt <= '0;
        phase   <= ~phase;
      end else begin
        frm_cnt <= frm_cnt + 32'd1;
      end
    end
  end

endmodule
